// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: processor-wide register file constants and exception status codes
package wb_regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int REG_ZERO = 0;
  localparam int REG_STATUS = 30;
  localparam logic [DATA_W-1:0] STATUS_NONE = 32'd0;
  localparam logic [DATA_W-1:0] STATUS_ADD_OVF = 32'd1;
  localparam logic [DATA_W-1:0] STATUS_SUB_OVF = 32'd3;
endpackage

// File: rtl/wb_regfile_reg_word.sv
// reg_word: one register word with synchronous active-high reset and write enable
module reg_word #(
  parameter int W = wb_regfile_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (we) q <= d;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: architectural register file with exception status write and write-through read bypass
module wb_regfile #(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W = wb_regfile_pkg::ADDR_W,
  parameter int NUM_REGS = 32,
  parameter int STATUS_REG = wb_regfile_pkg::REG_STATUS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              exc_we,
  input  logic [DATA_W-1:0] exc_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);
  import wb_regfile_pkg::*;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(STATUS_REG);
  logic [DATA_W-1:0] regs [NUM_REGS];
  assign regs[0] = '0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    logic is_stat, wr_en;
    logic [DATA_W-1:0] wr_d;
    assign is_stat = exc_we && (i == STATUS_REG);
    assign wr_en = is_stat || (we && write_reg == ADDR_W'(i));
    assign wr_d = is_stat ? exc_data : write_data;
    reg_word #(.W(DATA_W)) u_word (
      .clk(clock),
      .rst(reset),
      .we(wr_en),
      .d(wr_d),
      .q(regs[i])
    );
  end
  always_comb begin
    rs1_data = (reset || rs1_addr == ZERO_A) ? '0 :
               (exc_we && rs1_addr == STAT_A) ? exc_data :
               (we && rs1_addr == write_reg) ? write_data : regs[rs1_addr];
    rs2_data = (reset || rs2_addr == ZERO_A) ? '0 :
               (exc_we && rs2_addr == STAT_A) ? exc_data :
               (we && rs2_addr == write_reg) ? write_data : regs[rs2_addr];
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile
module tb_wb_regfile;
  import wb_regfile_pkg::*;
  logic clock = 0;
  logic reset, we, exc_we;
  logic [4:0] write_reg, rs1_addr, rs2_addr;
  logic [31:0] write_data, exc_data, rs1_data, rs2_data;
  int tests = 0;
  int fails = 0;
  always #5 clock = ~clock;
  wb_regfile dut (
    .clock(clock),
    .reset(reset),
    .we(we),
    .write_reg(write_reg),
    .write_data(write_data),
    .exc_we(exc_we),
    .exc_data(exc_data),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask
  task automatic edge_clear();
    @(posedge clock);
    #1;
    reset = 0;
    we = 0;
    exc_we = 0;
    #1;
  endtask
  initial begin
    reset = 1; we = 0; exc_we = 0; write_reg = 0; write_data = 0; exc_data = 0;
    rs1_addr = 5; rs2_addr = 31;
    @(posedge clock);
    #1;
    chk("reset_rs1", rs1_data, 32'h0);
    chk("reset_rs2", rs2_data, 32'h0);
    reset = 0;
    #1;
    chk("post_reset_rs1", rs1_data, 32'h0);
    chk("post_reset_rs2", rs2_data, 32'h0);
    reset = 1; we = 1; write_reg = 3; write_data = 32'hAAAA; rs1_addr = 3;
    #1;
    chk("reset_forces_zero", rs1_data, 32'h0);
    edge_clear();
    chk("reset_blocks_write_r3", rs1_data, 32'h0);
    we = 1; write_reg = 7; write_data = 32'h12345678; rs1_addr = 7; rs2_addr = 8;
    edge_clear();
    chk("write_r7", rs1_data, 32'h12345678);
    chk("r8_untouched", rs2_data, 32'h0);
    we = 1; write_reg = 0; write_data = 32'hFFFFFFFF; rs1_addr = 0;
    #1;
    chk("r0_bypass_zero", rs1_data, 32'h0);
    edge_clear();
    chk("r0_stays_zero", rs1_data, 32'h0);
    we = 1; write_reg = 4; write_data = 32'h11; rs1_addr = 4; rs2_addr = 4;
    edge_clear();
    chk("r4_stored", rs1_data, 32'h11);
    we = 1; write_data = 32'h22;
    #1;
    chk("bypass_rs1", rs1_data, 32'h22);
    chk("bypass_rs2", rs2_data, 32'h22);
    edge_clear();
    chk("r4_after_rs1", rs1_data, 32'h22);
    chk("r4_after_rs2", rs2_data, 32'h22);
    we = 1; write_reg = 30; write_data = 32'h5; exc_we = 1; exc_data = STATUS_ADD_OVF;
    rs1_addr = 30;
    #1;
    chk("collision_bypass", rs1_data, 32'h1);
    edge_clear();
    chk("collision_stored", rs1_data, 32'h1);
    we = 1; write_reg = 9; write_data = 32'h7; exc_we = 1; exc_data = STATUS_SUB_OVF;
    rs1_addr = 9; rs2_addr = 30;
    #1;
    chk("dual_bypass_r9", rs1_data, 32'h7);
    chk("dual_bypass_r30", rs2_data, 32'h3);
    edge_clear();
    chk("dual_stored_r9", rs1_data, 32'h7);
    chk("dual_stored_r30", rs2_data, 32'h3);
    we = 1; write_reg = 12; write_data = 32'hBEEF; rs1_addr = 12; rs2_addr = 4;
    edge_clear();
    chk("r12_beef", rs1_data, 32'hBEEF);
    chk("r4_kept", rs2_data, 32'h22);
    reset = 1; we = 1; write_reg = 12; write_data = 32'hCAFE;
    edge_clear();
    chk("r12_cleared", rs1_data, 32'h0);
    chk("r4_cleared", rs2_data, 32'h0);
    rs2_addr = 30;
    #1;
    chk("r30_cleared", rs2_data, 32'h0);
    we = 1; write_reg = 12; write_data = 32'hCAFE;
    edge_clear();
    chk("r12_resume", rs1_data, 32'hCAFE);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural register file at the end of the pipeline, directly downstream of the memory/writeback decoder.
- Consumes the decoder's write data, destination register and write enable.
- Also accepts a dedicated exception write to the status register (r30).
- Supplies two combinational read ports to the decode stage, with write-through bypass so a writeback is visible to decode in the same cycle.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of architectural registers (must equal 2**ADDR_W)
- STATUS_REG, 30, index of the status register targeted by exception writes

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- we  input  1  writeback enable from memory/writeback decoder
- write_reg  input  ADDR_W  writeback destination register
- write_data  input  DATA_W  writeback data (ALU result or load data)
- exc_we  input  1  exception write strobe; writes exc_data to STATUS_REG
- exc_data  input  DATA_W  exception status code
- rs1_addr  input  ADDR_W  read port 1 address
- rs2_addr  input  ADDR_W  read port 2 address
- rs1_data  output  DATA_W  read port 1 data (combinational)
- rs2_data  output  DATA_W  read port 2 data (combinational)

Behaviour:
- Storage: registers r1..r(NUM_REGS-1), each DATA_W bits. r0 is not stored: it reads as 0 and writes to it are discarded.
- Reset: when reset=1 at a rising edge, all stored registers clear to 0 and all writes in that cycle are ignored.
  - While reset=1, rs1_data and rs2_data are forced to 0.
  - Reset takes precedence over we and exc_we in the same cycle.
- Normal write: at a rising edge with reset=0, we=1 and write_reg!=0, reg[write_reg] <= write_data. Latency is one edge.
- Exception write: at a rising edge with reset=0 and exc_we=1, reg[STATUS_REG] <= exc_data.
- Collision: if we=1, write_reg==STATUS_REG and exc_we=1, exc_data wins.
  - Writes to different registers in the same cycle both complete.
- Read (combinational), per port p, evaluated in priority order:
  1. reset=1 -> 0
  2. rsp_addr==0 -> 0
  3. exc_we=1 and rsp_addr==STATUS_REG -> exc_data
  4. we=1 and rsp_addr==write_reg -> write_data
  5. otherwise -> reg[rsp_addr]
- Both read ports are independent; both may read the same address.
- Bypass has zero-cycle latency; the stored value updates at the next edge.
- Out-of-range addresses cannot occur because NUM_REGS = 2**ADDR_W.
- No combinational path from read addresses to stored state.

Decomposition:
- Shared package (processor-wide constants):
  - REG_ZERO = 0
  - REG_STATUS = 30
  - DATA_W, ADDR_W
  - Status code constants (e.g. add overflow = 1, sub overflow = 3), which exception sources drive onto exc_data.
- Sub-module: reg_word — one DATA_W flip-flop register with synchronous active-high reset and write enable.
  - Instantiated NUM_REGS-1 times.
  - The top level holds the write-address decoder, the exception priority mux and the two bypass read muxes.

Test Plan:
- Reset then read: assert reset 1 cycle, deassert; read rs1=5, rs2=31 -> both 0. While reset=1 with we=1, write_reg=3, write_data=0xAAAA -> rs outputs 0 and r3 remains 0 afterwards.
- Basic write/read: we=1, write_reg=7, write_data=0x12345678 for one edge; next cycle rs1_addr=7 -> 0x12345678. rs2_addr=8 -> 0.
- r0 immutability: we=1, write_reg=0, write_data=0xFFFFFFFF; rs1_addr=0 -> 0 in the same cycle and after the edge.
- Same-cycle bypass: r4 holds 0x11; drive we=1, write_reg=4, write_data=0x22 with rs1_addr=rs2_addr=4 -> both read 0x22 before the edge, and 0x22 after.
- Exception collision: we=1, write_reg=30, write_data=0x5; exc_we=1, exc_data=0x1 -> rs1_addr=30 reads 0x1 combinationally and r30=0x1 after the edge. Repeat with we=1, write_reg=9, write_data=0x7 plus exc_we=1, exc_data=0x3 -> r9=0x7, r30=0x3.
- Reset mid-stream: write r12=0xBEEF, then assert reset for one cycle together with we=1, write_reg=12, write_data=0xCAFE -> r12=0 after the edge; writes resume normally the cycle after reset deasserts.
